// File: rtl/pipeline_types_pkg.sv
// Types shared between the Fetch and Decode stages, including the
// fetch/decode payload and the default fetch queue depth.
package pipeline_types;

  localparam int FETCH_Q_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_dec_t;

endpackage

// File: rtl/fetch_queue_wrap_ptr.sv
// Circular index for the fetch queue. It wraps at DEPTH-1 by an explicit
// compare, so any depth works, including depths that are not powers of two.
module wrap_ptr #(
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          clr,
  output logic [PW-1:0] ptr
);

  // clr wins over inc so that a flush always lands both pointers on entry 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Elastic fetch->decode queue with flush and occupancy status.
// Optional macro FETCH_QUEUE_BYPASS_EN gives a 0-cycle path when the queue is empty.
module fetch_queue
  import pipeline_types::*;
#(
  parameter int WIDTH    = $bits(fetch_dec_t),
  parameter int DEPTH    = FETCH_Q_DEPTH,
  parameter int AF_LEVEL = DEPTH - 1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [WIDTH-1:0] data_out,
  output logic [CW-1:0]    count_o,
  output logic             almost_full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             stored_valid;
  logic             bypass;
  logic             bypass_take;
  logic             push;
  logic             pop;
  logic             wr_en;
  logic             rd_en;

  assign stored_valid = (count != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = !stored_valid && valid_in && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  // ready_in depends only on stored occupancy, never on ready_out
  assign ready_in  = (count != CW'(DEPTH));
  assign valid_out = stored_valid || bypass;

  always_comb begin
    data_out = '0;
    if (stored_valid) begin
      data_out = mem[rd_ptr];
    end else if (bypass) begin
      data_out = data_in;
    end
  end

  assign push        = valid_in && ready_in;
  assign pop         = valid_out && ready_out;
  assign bypass_take = bypass && ready_out;
  assign wr_en       = push && !flush_i && !bypass_take;
  assign rd_en       = pop && stored_valid && !flush_i;

  wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_en),
    .clr   (flush_i),
    .ptr   (wr_ptr)
  );

  wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_en),
    .clr   (flush_i),
    .ptr   (rd_ptr)
  );

  // Payload storage is deliberately left out of reset; data_out is gated by count
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (flush_i) begin
      count <= '0;
    end else if (wr_en && !rd_en) begin
      count <= count + 1'b1;
    end else if (rd_en && !wr_en) begin
      count <= count - 1'b1;
    end
  end

  assign count_o       = count;
  assign almost_full_o = (count >= CW'(AF_LEVEL));
  assign empty_o       = (count == '0);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue: a DEPTH=4 instance for the
// main scenarios and a DEPTH=3 instance for non-power-of-two wrap.
module tb_fetch_queue;

  logic clk = 1'b0;
  logic reset;

  logic        a_flush, a_vin, a_rin, a_vout, a_rout, a_af, a_empty;
  logic [63:0] a_din, a_dout;
  logic [2:0]  a_cnt;

  logic        b_flush, b_vin, b_rin, b_vout, b_rout, b_af, b_empty;
  logic [63:0] b_din, b_dout;
  logic [1:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_queue #(.WIDTH(64), .DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (a_flush),
    .valid_in      (a_vin),
    .ready_in      (a_rin),
    .data_in       (a_din),
    .valid_out     (a_vout),
    .ready_out     (a_rout),
    .data_out      (a_dout),
    .count_o       (a_cnt),
    .almost_full_o (a_af),
    .empty_o       (a_empty)
  );

  fetch_queue #(.WIDTH(64), .DEPTH(3)) dut3 (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (b_flush),
    .valid_in      (b_vin),
    .ready_in      (b_rin),
    .data_in       (b_din),
    .valid_out     (b_vout),
    .ready_out     (b_rout),
    .data_out      (b_dout),
    .count_o       (b_cnt),
    .almost_full_o (b_af),
    .empty_o       (b_empty)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int recv;
    int cyc;

    reset   = 1'b1;
    a_flush = 1'b0; a_vin = 1'b0; a_rout = 1'b0; a_din = '0;
    b_flush = 1'b0; b_vin = 1'b0; b_rout = 1'b0; b_din = '0;
    #12;
    reset = 1'b0;
    #1;
    checkOutput("init_count", 64'(a_cnt), 64'd0);
    checkOutput("init_empty", 64'(a_empty), 64'd1);
    checkOutput("init_ready_in", 64'(a_rin), 64'd1);
    checkOutput("init_valid_out", 64'(a_vout), 64'd0);

    // Fill with ready_out low; fifth push must be refused
    applyStimulus();
    for (int i = 0; i < 5; i++) begin
      a_vin = 1'b1;
      a_din = 64'hA0 + 64'(i);
      #1;
      checkOutput("fill_ready_in", 64'(a_rin), (i < 4) ? 64'd1 : 64'd0);
      applyStimulus();
      checkOutput("fill_count", 64'(a_cnt), (i < 4) ? 64'(i + 1) : 64'd4);
      checkOutput("fill_af", 64'(a_af), (i >= 2) ? 64'd1 : 64'd0);
      checkOutput("fill_hold_data", a_dout, 64'hA0);
    end
    a_vin  = 1'b0;
    a_rout = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("drain_valid", 64'(a_vout), 64'd1);
      checkOutput("drain_data", a_dout, 64'hA0 + 64'(i));
      applyStimulus();
    end
    checkOutput("drain_empty", 64'(a_empty), 64'd1);
    checkOutput("drain_valid_low", 64'(a_vout), 64'd0);
    checkOutput("drain_data_zero", a_dout, 64'd0);

    // Prefill two entries, then stream 20 cycles with both sides ready
    a_rout = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_vin = 1'b1;
      a_din = 64'h100 + 64'(i);
      applyStimulus();
    end
    a_rout = 1'b1;
    for (int k = 0; k < 20; k++) begin
      a_din = 64'h102 + 64'(k);
      #1;
      checkOutput("stream_data", a_dout, 64'h100 + 64'(k));
      applyStimulus();
      checkOutput("stream_count", 64'(a_cnt), 64'd2);
    end
    a_vin = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("stream_drained", 64'(a_empty), 64'd1);

    // Flush at count 3 with a concurrent push that must be dropped
    a_rout = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_vin = 1'b1;
      a_din = 64'hD0 + 64'(i);
      applyStimulus();
    end
    checkOutput("preflush_count", 64'(a_cnt), 64'd3);
    a_flush = 1'b1;
    a_din   = 64'hBEEF;
    applyStimulus();
    a_flush = 1'b0;
    a_vin   = 1'b0;
    checkOutput("flush_count", 64'(a_cnt), 64'd0);
    checkOutput("flush_valid", 64'(a_vout), 64'd0);
    a_rout = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("flush_no_beef", a_dout, 64'd0);
    end
    a_rout = 1'b0;
    a_vin  = 1'b1;
    a_din  = 64'hE0;
    applyStimulus();
    a_vin = 1'b0;
    checkOutput("postflush_data", a_dout, 64'hE0);
    a_rout = 1'b1;
    applyStimulus();
    a_rout = 1'b0;

    // Reset asserted mid-cycle while holding three entries
    for (int i = 0; i < 3; i++) begin
      a_vin = 1'b1;
      a_din = 64'hF0 + 64'(i);
      applyStimulus();
    end
    a_vin = 1'b0;
    checkOutput("prereset_count", 64'(a_cnt), 64'd3);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("reset_valid", 64'(a_vout), 64'd0);
    checkOutput("reset_count", 64'(a_cnt), 64'd0);
    checkOutput("reset_empty", 64'(a_empty), 64'd1);
    checkOutput("reset_ready_in", 64'(a_rin), 64'd1);
    checkOutput("reset_data", a_dout, 64'd0);
    checkOutput("reset_af", 64'(a_af), 64'd0);
    applyStimulus();
    #2;
    reset = 1'b0;
    applyStimulus();

    // DEPTH=3 instance: ten entries with random ready_out
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 10 && cyc < 200) begin
      b_vin  = (sent < 10);
      b_din  = 64'h300 + 64'(sent);
      b_rout = 1'($urandom_range(0, 1));
      #1;
      if (b_vout && b_rout) begin
        checkOutput("wrap_data", b_dout, 64'h300 + 64'(recv));
        recv++;
      end
      if (b_vin && b_rin) sent++;
      applyStimulus();
      checkOutput("wrap_count", 64'(b_cnt), 64'(sent - recv));
      cyc++;
    end
    b_vin  = 1'b0;
    b_rout = 1'b0;
    checkOutput("wrap_done", 64'(recv), 64'd10);

    // Empty queue, push 0x55 with ready_out high
    a_vin  = 1'b1;
    a_din  = 64'h55;
    a_rout = 1'b1;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    checkOutput("bypass_valid", 64'(a_vout), 64'd1);
    checkOutput("bypass_data", a_dout, 64'h55);
    checkOutput("bypass_count", 64'(a_cnt), 64'd0);
    applyStimulus();
    a_vin = 1'b0;
    checkOutput("bypass_count_after", 64'(a_cnt), 64'd0);
    checkOutput("bypass_valid_after", 64'(a_vout), 64'd0);
`else
    checkOutput("nobypass_valid", 64'(a_vout), 64'd0);
    checkOutput("nobypass_count", 64'(a_cnt), 64'd0);
    applyStimulus();
    a_vin = 1'b0;
    checkOutput("nobypass_count_after", 64'(a_cnt), 64'd1);
    checkOutput("nobypass_valid_after", 64'(a_vout), 64'd1);
    checkOutput("nobypass_data_after", a_dout, 64'h55);
    applyStimulus();
    checkOutput("nobypass_popped", 64'(a_cnt), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised N-entry elastic buffer between Fetch and decode; successor to the 2-entry fetch/decode skid buffer.
- Carries a fetch_dec_t-sized payload (pc, inst) with valid/ready handshakes on both sides.
- Adds configurable depth, a synchronous flush for branch/jump redirects, and occupancy/almost-full status so Fetch can throttle ahead of a stall.

Parameters:
WIDTH, 64, payload width in bits (normally $bits(fetch_dec_t)).
DEPTH, 4, number of entries; legal range 2..64; need not be a power of two.
AF_LEVEL, DEPTH-1, occupancy at or above which almost_full_o asserts; legal range 1..DEPTH.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all control state
flush_i  input  1  synchronous discard of all entries (redirect)
valid_in  input  1  upstream entry valid
ready_in  output  1  queue can accept; = !full, no combinational path from ready_out
data_in  input  WIDTH  upstream payload
valid_out  output  1  head entry valid
ready_out  input  1  downstream accepts head
data_out  output  WIDTH  head payload
count_o  output  $clog2(DEPTH+1)  current occupancy
almost_full_o  output  1  count_o >= AF_LEVEL
empty_o  output  1  count_o == 0

Behaviour:
- Reset (async assert): wr_ptr=0, rd_ptr=0, count=0. Outputs during and after reset: valid_out=0, ready_in=1, data_out=0, count_o=0, empty_o=1, almost_full_o=0 (AF_LEVEL>=1). Storage array is not reset.
- push = valid_in & ready_in; pop = valid_out & ready_out.
- Push writes mem[wr_ptr] and advances wr_ptr. Pop advances rd_ptr. Both pointers wrap from DEPTH-1 to 0 with explicit compare, not modulo 2^n.
- count next value: +1 on push only, -1 on pop only, unchanged on push&pop.
- Simultaneous push&pop when full: not possible, since ready_in=0 while full.
- Push into empty: entry is visible at valid_out the next cycle (1-cycle latency).
- data_out = mem[rd_ptr] when count!=0, else 0. It must hold stable while valid_out=1 and ready_out=0.
- valid_out = (count != 0). Once asserted, it never drops without a pop or flush.
- flush_i=1: next cycle count=0 and wr_ptr=rd_ptr=0.
  - A push in the flush cycle is dropped.
  - A pop in the flush cycle still counts as a handshake downstream, but has no state effect beyond the flush.
  - ready_in stays 1 during flush.
- flush_i has priority over push/pop. reset has priority over everything, including mid-flush.
- Ordering is strict FIFO; no entry is lost or duplicated except by flush.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when count==0 and valid_in=1 and flush_i=0, valid_out=1 and data_out=data_in combinationally (0-cycle latency).
  - If ready_out=1 in that cycle, the entry is consumed and neither written nor counted.
  - If ready_out=0, it is written normally.
- Not defined: no valid_in->valid_out or data_in->data_out path; latency is always at least 1 cycle.
- Status outputs (count_o, empty_o, almost_full_o) reflect stored entries only in both builds.

Decomposition:
- pipeline_types package: add localparam FETCH_Q_DEPTH=4. fetch_dec_t already lives there, and the top instantiates with WIDTH=$bits(fetch_dec_t).
- One sub-module, wrap_ptr: parametrised DEPTH, inputs inc and clr, output ptr with wrap-at-DEPTH-1; instantiated twice.
- Storage stays a plain array inside fetch_queue.

Test Plan:
1. Reset mid-traffic, DEPTH=4, count=3: assert reset asynchronously -> same cycle valid_out=0, count_o=0, empty_o=1, ready_in=1, data_out=0.
2. Fill with ready_out=0, pushing 0x...A0..A3 -> count_o goes 1,2,3,4; almost_full_o rises at count 3; ready_in=0 at 4; fifth push ignored. Then ready_out=1 -> A0,A1,A2,A3 emitted in order, one per cycle, then empty_o=1.
3. Steady stream with valid_in=ready_out=1 for 20 cycles at count=2 -> count_o constant 2; output sequence equals input sequence delayed 2 handshakes.
4. Wrap on non-power-of-two, DEPTH=3: push/pop 10 entries with random ready_out -> in-order delivery; pointers pass 2->0 cleanly.
5. Flush at count=3 with simultaneous push of 0xBEEF -> next cycle count_o=0 and valid_out=0; 0xBEEF never appears at data_out.
6. Bypass build: empty queue, valid_in=1, data_in=0x55, ready_out=1 -> valid_out=1 and data_out=0x55 in the same cycle, count_o stays 0. Without the macro -> valid_out rises one cycle later and count_o briefly reads 1.
